// File: rtl/muldiv_scheduler_if.sv
// HI/LO multiply-divide scheduler port bundle.
// master: pipeline side, slave: scheduler side.
interface muldiv_scheduler_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic [1:0]       i_op;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_flush;
  logic             i_hi_we;
  logic             i_lo_we;
  logic [WIDTH-1:0] i_wdata;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;

  modport master (
    output i_start, i_op, i_a, i_b,
    output i_flush, i_hi_we, i_lo_we, i_wdata,
    input  o_busy, o_done, o_hi, o_lo
  );

  modport slave (
    input  i_start, i_op, i_a, i_b,
    input  i_flush, i_hi_we, i_lo_we, i_wdata,
    output o_busy, o_done, o_hi, o_lo
  );
endinterface

// File: rtl/muldiv_scheduler.sv
// HI/LO owner sequencing MULT/MULTU/DIV/DIVU with flush and MTHI/MTLO.
// Optional DIV_ZERO_FAST_EN: divide by zero skips straight to FIX.
module muldiv_scheduler #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input logic               clk,
  input logic               resetn,
  muldiv_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = WIDTH + 1;

  state_t             state;
  state_t             state_n;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_s;
  logic               op_div;
  logic               qneg;
  logic               rneg;
  logic               dz;
  logic               launch;
  logic               is_div;
  logic               is_sgn;
  logic               dz_now;
  logic               idle_wr;
  logic               fix_wr;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH+1:0]   trial;
  logic               ge;

  assign is_div = bus.i_op[1];
  assign is_sgn = ~bus.i_op[0];
  assign abs_a  = (is_sgn & bus.i_a[WIDTH-1])
                ? -bus.i_a : bus.i_a;
  assign abs_b  = (is_sgn & bus.i_b[WIDTH-1])
                ? -bus.i_b : bus.i_b;
  assign launch = (state == IDLE) & bus.i_start
                & ~bus.i_flush;
  assign idle_wr = (state == IDLE) & ~launch;
  assign fix_wr  = (state == FIX) & ~bus.i_flush;

`ifdef DIV_ZERO_FAST_EN
  assign dz_now = is_div & (bus.i_b == '0);
`else
  assign dz_now = 1'b0;
`endif

  // Restoring step: shift next dividend bit into the remainder
  assign trial = {rem, quo[WIDTH-1]};
  assign ge    = trial >= {2'b00, dvs};

  assign bus.o_busy = bus.i_start | (state != IDLE);
  assign bus.o_done = fix_wr;
  assign bus.o_hi   = hi;
  assign bus.o_lo   = lo;

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (launch)
              state_n = dz_now ? FIX
                      : (is_div ? DIV : MUL);
      MUL:  if (cnt == CW'(MUL_STAGES - 1))
              state_n = FIX;
      DIV:  if (cnt == CW'(WIDTH - 1))
              state_n = FIX;
      FIX:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (bus.i_flush) state_n = IDLE;
  end

  always_comb begin
    prod_s = qneg ? -prod : prod;
    fix_hi = prod_s[2*WIDTH-1:WIDTH];
    fix_lo = prod_s[WIDTH-1:0];
    if (dz) begin
      fix_hi = rem[WIDTH-1:0];
      fix_lo = quo;
    end else if (op_div) begin
      fix_hi = rneg ? -rem[WIDTH-1:0]
                    : rem[WIDTH-1:0];
      fix_lo = qneg ? -quo : quo;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      prod   <= '0;
      op_div <= 1'b0;
      qneg   <= 1'b0;
      rneg   <= 1'b0;
      dz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      unique case (1'b1)
        launch: begin
          cnt    <= '0;
          op_div <= is_div;
          dz     <= dz_now;
          qneg   <= is_sgn &
                    (bus.i_a[WIDTH-1] ^ bus.i_b[WIDTH-1]);
          rneg   <= is_sgn & bus.i_a[WIDTH-1];
          dvs    <= abs_b;
          rem    <= '0;
          quo    <= abs_a;
`ifdef DIV_ZERO_FAST_EN
          if (dz_now) begin
            rem <= {1'b0, bus.i_a};
            quo <= '1;
          end
`endif
        end
        (state == MUL): begin
          cnt  <= cnt + CW'(1);
          prod <= {{WIDTH{1'b0}}, quo}
                * {{WIDTH{1'b0}}, dvs};
        end
        (state == DIV): begin
          cnt <= cnt + CW'(1);
          rem <= ge ? RW'(trial - {2'b00, dvs})
                    : trial[WIDTH:0];
          quo <= {quo[WIDTH-2:0], ge};
        end
        fix_wr: begin
          hi <= fix_hi;
          lo <= fix_lo;
        end
        idle_wr: begin
          if (bus.i_hi_we) hi <= bus.i_wdata;
          if (bus.i_lo_we) lo <= bus.i_wdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_scheduler.sv
// Randomised and directed checks of muldiv_scheduler
// against an arithmetic reference model.
module tb_muldiv_scheduler;
  localparam int W  = 32;
  localparam int MS = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  muldiv_scheduler_if #(.WIDTH(W)) bus();

  muldiv_scheduler #(
    .WIDTH(W),
    .MUL_STAGES(MS)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  // reference model state
  int          left = 0;
  bit          started = 0;
  logic [31:0] mhi, mlo;
  bit          hv, lv;
  logic [31:0] pend_h, pend_l;
  bit          pend_k;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h @%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic compute(input logic [1:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         output logic [31:0] h,
                         output logic [31:0] l,
                         output bit k,
                         output int lat);
    longint sa, sb, sp, q, r;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    k = 1;
    lat = MS + 1;
    h = '0;
    l = '0;
    case (op)
      2'b00: begin
        sp = sa * sb;
        h = sp[63:32];
        l = sp[31:0];
      end
      2'b01: begin
        up = {32'b0, a} * {32'b0, b};
        h = up[63:32];
        l = up[31:0];
      end
      default: begin
        lat = W + 1;
        if (b == 0) begin
`ifdef DIV_ZERO_FAST_EN
          lat = 1;
          h = a;
          l = '1;
`else
          k = 0;
`endif
        end else if (op == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          h = r[31:0];
          l = q[31:0];
        end else begin
          h = a % b;
          l = a / b;
        end
      end
    endcase
  endtask

  always @(posedge clk) begin
    int lat;
    if (!resetn) begin
      left = 0;
      mhi = '0;
      mlo = '0;
      hv = 1;
      lv = 1;
      started = 1;
    end else if (left != 0) begin
      if (bus.i_flush) left = 0;
      else if (left == 1) begin
        mhi = pend_h;
        mlo = pend_l;
        hv = pend_k;
        lv = pend_k;
        left = 0;
      end else left--;
    end else if (bus.i_start && !bus.i_flush) begin
      compute(bus.i_op, bus.i_a, bus.i_b,
              pend_h, pend_l, pend_k, lat);
      left = lat;
    end else begin
      if (bus.i_hi_we) begin mhi = bus.i_wdata; hv = 1; end
      if (bus.i_lo_we) begin mlo = bus.i_wdata; lv = 1; end
    end
  end

  always @(negedge clk) begin
    if (bus.o_done) done_cnt++;
    if (started && resetn) begin
      chk("busy", {31'b0, bus.o_busy},
          {31'b0, bus.i_start | (left != 0)});
      chk("done", {31'b0, bus.o_done},
          {31'b0, (left == 1) & ~bus.i_flush});
      if (hv) chk("hi", bus.o_hi, mhi);
      if (lv) chk("lo", bus.o_lo, mlo);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.i_start = 0;
    bus.i_flush = 0;
    bus.i_hi_we = 0;
    bus.i_lo_we = 0;
  endtask

  task automatic run_op(input logic [1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        output int done_at,
                        output int busy_n);
    bit fin = 0;
    done_at = -1;
    busy_n = 0;
    tick();
    bus.i_start = 1;
    bus.i_op = op;
    bus.i_a = a;
    bus.i_b = b;
    for (int k = 0; k < 100 && !fin; k++) begin
      @(negedge clk);
      if (bus.o_busy) busy_n++;
      if (bus.o_done) done_at = k;
      if (k > 0 && !bus.o_busy) fin = 1;
      else begin
        @(posedge clk);
        #1;
        bus.i_start = 0;
      end
    end
    if (!fin) begin
      tests++;
      fails++;
      $display("FAIL run_op timeout op=%0d", op);
    end
  endtask

  function automatic logic [31:0] rval();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = $urandom_range(0, 20);
      2: v = -$urandom_range(1, 20);
      3: v = 32'h8000_0000;
      4: v = 32'hFFFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int d, bz, d0, n;
    clr();
    bus.i_op = 0;
    bus.i_a = 0;
    bus.i_b = 0;
    bus.i_wdata = 0;
    tick();
    tick();
    resetn = 1;
    @(negedge clk);
    chk("rst_hi", bus.o_hi, 32'h0);
    chk("rst_lo", bus.o_lo, 32'h0);
    chk("rst_busy", {31'b0, bus.o_busy}, 32'h0);

    run_op(2'b11, 32'd100, 32'd7, d, bz);
    chk("divu_done_at", d, 33);
    chk("divu_busy_n", bz, 34);
    chk("divu_lo", bus.o_lo, 32'd14);
    chk("divu_hi", bus.o_hi, 32'd2);

    run_op(2'b10, -32'sd7, 32'd2, d, bz);
    chk("div1_lo", bus.o_lo, 32'hFFFF_FFFD);
    chk("div1_hi", bus.o_hi, 32'hFFFF_FFFF);
    run_op(2'b10, 32'd7, -32'sd2, d, bz);
    chk("div2_lo", bus.o_lo, 32'hFFFF_FFFD);
    chk("div2_hi", bus.o_hi, 32'd1);

    run_op(2'b00, 32'hFFFF_FFFF, 32'd3, d, bz);
    chk("mult_done_at", d, 3);
    chk("mult_hi", bus.o_hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.o_lo, 32'hFFFF_FFFD);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd3, d, bz);
    chk("multu_hi", bus.o_hi, 32'd2);
    chk("multu_lo", bus.o_lo, 32'hFFFF_FFFD);

    // flush mid-divide, then relaunch next cycle
    tick();
    bus.i_hi_we = 1;
    bus.i_lo_we = 1;
    bus.i_wdata = 32'h55;
    tick();
    clr();
    bus.i_start = 1;
    bus.i_op = 2'b11;
    bus.i_a = 32'd1000;
    bus.i_b = 32'd3;
    d0 = done_cnt;
    for (int k = 1; k <= 10; k++) begin
      tick();
      bus.i_start = 0;
      bus.i_flush = (k == 10);
    end
    tick();
    bus.i_flush = 0;
    bus.i_start = 1;
    bus.i_op = 2'b01;
    bus.i_a = 32'd6;
    bus.i_b = 32'd7;
    @(negedge clk);
    chk("flush_no_done", done_cnt - d0, 0);
    chk("flush_hi", bus.o_hi, 32'h55);
    chk("flush_lo", bus.o_lo, 32'h55);
    tick();
    bus.i_start = 0;
    n = 0;
    for (int k = 1; k < 20 && n == 0; k++) begin
      @(negedge clk);
      if (bus.o_done) n = k;
    end
    chk("relaunch_done_at", n, 3);
    tick();
    @(negedge clk);
    chk("relaunch_lo", bus.o_lo, 32'd42);

    // MTLO while idle
    tick();
    bus.i_lo_we = 1;
    bus.i_wdata = 32'h1234;
    tick();
    clr();
    @(negedge clk);
    chk("mtlo", bus.o_lo, 32'h1234);

    // MTHI and i_start during DIV are ignored
    tick();
    bus.i_start = 1;
    bus.i_op = 2'b11;
    bus.i_a = 32'd100;
    bus.i_b = 32'd7;
    for (int k = 1; k <= 40; k++) begin
      tick();
      bus.i_start = (k == 5);
      bus.i_hi_we = (k == 5);
      bus.i_op = 2'b00;
      bus.i_wdata = 32'hDEAD;
    end
    clr();
    @(negedge clk);
    chk("mthi_ign_hi", bus.o_hi, 32'd2);
    chk("start_ign_lo", bus.o_lo, 32'd14);

`ifdef DIV_ZERO_FAST_EN
    run_op(2'b10, 32'd9, 32'd0, d, bz);
    chk("dz_done_at", d, 1);
    chk("dz_busy_n", bz, 2);
    chk("dz_hi", bus.o_hi, 32'd9);
    chk("dz_lo", bus.o_lo, 32'hFFFF_FFFF);
`endif

    // reset mid-operation
    tick();
    bus.i_start = 1;
    bus.i_op = 2'b10;
    bus.i_a = 32'd77;
    bus.i_b = 32'd5;
    for (int k = 0; k < 5; k++) begin
      tick();
      bus.i_start = 0;
    end
    resetn = 0;
    tick();
    resetn = 1;
    @(negedge clk);
    chk("rstmid_hi", bus.o_hi, 32'h0);
    chk("rstmid_lo", bus.o_lo, 32'h0);
    chk("rstmid_busy", {31'b0, bus.o_busy}, 32'h0);

    for (int c = 0; c < 3000; c++) begin
      tick();
      bus.i_start = ($urandom_range(0, 2) == 0);
      bus.i_op = 2'($urandom_range(0, 3));
      bus.i_a = rval();
      bus.i_b = rval();
      bus.i_flush = ($urandom_range(0, 39) == 0);
      bus.i_hi_we = ($urandom_range(0, 7) == 0);
      bus.i_lo_we = ($urandom_range(0, 7) == 0);
      bus.i_wdata = $urandom;
    end
    tick();
    clr();
    n = 0;
    for (int k = 0; k < 50 && n == 0; k++) begin
      @(negedge clk);
      if (!bus.o_busy) n = 1;
      else tick();
    end
    chk("drain_idle", n, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
